// File: rtl/multi_alarm_if.sv
// Bus bundle between the timekeeping logic and the multi-channel alarm unit.
interface multi_alarm_if #(
    parameter int unsigned N_ALARMS = 4,
    parameter int unsigned TIME_W   = 17
);
    localparam int unsigned SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic [TIME_W-1:0]   time_in;
    logic                sec_tick;
    logic                set_time;
    logic [SEL_W-1:0]    set_idx;
    logic [TIME_W-1:0]   time_set_in;
    logic [N_ALARMS-1:0] en_in;
    logic                snooze;
    logic                end_ring;
    logic [N_ALARMS-1:0] ring;
    logic [N_ALARMS-1:0] snoozed;
    logic                any_ring;

    modport master (
        output time_in, sec_tick, set_time, set_idx, time_set_in,
               en_in, snooze, end_ring,
        input  ring, snoozed, any_ring
    );

    modport slave (
        input  time_in, sec_tick, set_time, set_idx, time_set_in,
               en_in, snooze, end_ring,
        output ring, snoozed, any_ring
    );
endinterface

// File: rtl/multi_alarm.sv
// N-channel alarm unit: per-channel alarm time, edge-triggered ringing,
// shared snooze/stop controls, snooze limit and ring timeout.
module multi_alarm #(
    parameter int unsigned N_ALARMS     = 4,
    parameter int unsigned TIME_W       = 17,
    parameter int unsigned DAY_SEC      = 86400,
    parameter int unsigned SNOOZE_SEC   = 300,
    parameter int unsigned MAX_SNOOZE   = 3,
    parameter int unsigned RING_TIMEOUT = 60
) (
    input  logic           clk,
    input  logic           rst,
    multi_alarm_if.slave   bus
);
    localparam int unsigned SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int unsigned TW1   = TIME_W + 1;
    localparam int unsigned CNT_W = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
    localparam int unsigned SNZ_W = $clog2(MAX_SNOOZE + 1) > 0 ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZED = 2'd2;

    logic [TIME_W-1:0]   alarm_q    [N_ALARMS];
    logic [TIME_W-1:0]   alarm_d    [N_ALARMS];
    logic [TIME_W-1:0]   target_q   [N_ALARMS];
    logic [TIME_W-1:0]   target_d   [N_ALARMS];
    logic [1:0]          state_q    [N_ALARMS];
    logic [1:0]          state_d    [N_ALARMS];
    logic [CNT_W-1:0]    ring_cnt_q [N_ALARMS];
    logic [CNT_W-1:0]    ring_cnt_d [N_ALARMS];
    logic [SNZ_W-1:0]    snz_cnt_q  [N_ALARMS];
    logic [SNZ_W-1:0]    snz_cnt_d  [N_ALARMS];

    logic [N_ALARMS-1:0] match_prev_q, match_prev_d;
    logic [N_ALARMS-1:0] ring_q, ring_d;
    logic [N_ALARMS-1:0] snoozed_q, snoozed_d;
    logic                any_ring_q, any_ring_d;

    logic [N_ALARMS-1:0] match_c;
    logic [N_ALARMS-1:0] sel_c;
    logic [N_ALARMS-1:0] rise_c;
    logic [TW1-1:0]      snz_sum_c;
    logic [TIME_W-1:0]   snz_target_c;

    // Snooze target, wrapped into the next day when it passes midnight.
    always_comb begin
        snz_target_c = '0;
        snz_sum_c    = {1'b0, bus.time_in} + TW1'(SNOOZE_SEC);
        if (snz_sum_c >= TW1'(DAY_SEC)) begin
            snz_target_c = TIME_W'(snz_sum_c - TW1'(DAY_SEC));
        end else begin
            snz_target_c = snz_sum_c[TIME_W-1:0];
        end
    end

    // Per-channel match, set-select and rising-edge detection.
    always_comb begin
        match_c      = '0;
        sel_c        = '0;
        rise_c       = '0;
        match_prev_d = '0;
        for (int unsigned i = 0; i < N_ALARMS; i++) begin
            match_c[i] = (bus.time_in == alarm_q[i]);
            sel_c[i]   = bus.set_time
                         && (32'(bus.set_idx) < N_ALARMS)
                         && (bus.set_idx == SEL_W'(i));
            rise_c[i]  = match_c[i] & ~match_prev_q[i] & ~sel_c[i];
        end
        match_prev_d = match_c;
    end

    // Next-state and output decode for every channel.
    always_comb begin
        alarm_d    = alarm_q;
        target_d   = target_q;
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        ring_d     = '0;
        snoozed_d  = '0;
        any_ring_d = 1'b0;

        for (int unsigned i = 0; i < N_ALARMS; i++) begin
            if (sel_c[i]) begin
                alarm_d[i] = bus.time_set_in;
                state_d[i] = ST_IDLE;
            end else if (!bus.en_in[i]) begin
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (rise_c[i]) begin
                            state_d[i]    = ST_RINGING;
                            ring_cnt_d[i] = '0;
                            snz_cnt_d[i]  = '0;
                        end
                    end
                    ST_RINGING: begin
                        if (bus.end_ring) begin
                            state_d[i] = ST_IDLE;
                        end else if (bus.snooze && (snz_cnt_q[i] == SNZ_W'(MAX_SNOOZE))) begin
                            state_d[i] = ST_IDLE;
                        end else if (bus.snooze) begin
                            state_d[i]   = ST_SNOOZED;
                            snz_cnt_d[i] = snz_cnt_q[i] + SNZ_W'(1);
                            target_d[i]  = snz_target_c;
                        end else if (bus.sec_tick) begin
                            if (ring_cnt_q[i] == CNT_W'(RING_TIMEOUT - 1)) begin
                                state_d[i] = ST_IDLE;
                            end else begin
                                ring_cnt_d[i] = ring_cnt_q[i] + CNT_W'(1);
                            end
                        end
                    end
                    ST_SNOOZED: begin
                        // A fresh alarm match is ignored here; only the snooze target re-rings.
                        if (bus.end_ring) begin
                            state_d[i] = ST_IDLE;
                        end else if (bus.time_in == target_q[i]) begin
                            state_d[i]    = ST_RINGING;
                            ring_cnt_d[i] = '0;
                        end
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
            ring_d[i]    = (state_d[i] == ST_RINGING);
            snoozed_d[i] = (state_d[i] == ST_SNOOZED);
        end
        any_ring_d = |ring_d;
    end

    // State and output registers; match history resets high so time 0 does not fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_ALARMS; i++) begin
                alarm_q[i]    <= '0;
                target_q[i]   <= '0;
                state_q[i]    <= ST_IDLE;
                ring_cnt_q[i] <= '0;
                snz_cnt_q[i]  <= '0;
            end
            match_prev_q <= '1;
            ring_q       <= '0;
            snoozed_q    <= '0;
            any_ring_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_ALARMS; i++) begin
                alarm_q[i]    <= alarm_d[i];
                target_q[i]   <= target_d[i];
                state_q[i]    <= state_d[i];
                ring_cnt_q[i] <= ring_cnt_d[i];
                snz_cnt_q[i]  <= snz_cnt_d[i];
            end
            match_prev_q <= match_prev_d;
            ring_q       <= ring_d;
            snoozed_q    <= snoozed_d;
            any_ring_q   <= any_ring_d;
        end
    end

    assign bus.ring     = ring_q;
    assign bus.snoozed  = snoozed_q;
    assign bus.any_ring = any_ring_q;

endmodule

// File: tb/tb_multi_alarm.sv
// Directed self-checking bench for multi_alarm with hand-computed expectations.
module tb_multi_alarm;
    localparam int unsigned N  = 4;
    localparam int unsigned TW = 17;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    multi_alarm_if #(.N_ALARMS(N), .TIME_W(TW)) bus ();

    multi_alarm #(
        .N_ALARMS(N), .TIME_W(TW), .DAY_SEC(86400), .SNOOZE_SEC(300),
        .MAX_SNOOZE(3), .RING_TIMEOUT(60)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; inputs changed afterwards are stable well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance time of day by one second-tick cycle.
    task automatic step_sec(input int unsigned t);
        bus.time_in  = TW'(t);
        bus.sec_tick = 1'b1;
        tick();
        bus.sec_tick = 1'b0;
    endtask

    task automatic set_alarm(input int unsigned idx, input int unsigned t);
        bus.set_time    = 1'b1;
        bus.set_idx     = 2'(idx);
        bus.time_set_in = TW'(t);
        tick();
        bus.set_time    = 1'b0;
    endtask

    task automatic pulse_snooze();
        bus.snooze = 1'b1;
        tick();
        bus.snooze = 1'b0;
    endtask

    task automatic pulse_end();
        bus.end_ring = 1'b1;
        tick();
        bus.end_ring = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst              = 1'b0;
        bus.time_in      = '0;
        bus.sec_tick     = 1'b0;
        bus.set_time     = 1'b0;
        bus.set_idx      = '0;
        bus.time_set_in  = '0;
        bus.en_in        = 4'b0001;
        bus.snooze       = 1'b0;
        bus.end_ring     = 1'b0;

        // 1: time 0 at reset release must not trigger alarm0=0
        tick();
        tick();
        chk("rst_ring", 32'(bus.ring), 32'h0);
        chk("rst_snoozed", 32'(bus.snoozed), 32'h0);
        chk("rst_any", 32'(bus.any_ring), 32'h0);
        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("t0_no_trigger", 32'(bus.ring), 32'h0);
        step_sec(1);
        step_sec(0);
        chk("t0_retrigger", 32'(bus.ring), 32'h1);
        chk("t0_any", 32'(bus.any_ring), 32'h1);
        pulse_end();
        chk("t0_end", 32'(bus.ring), 32'h0);

        // 2: alarm1=100, match held several clocks
        set_alarm(1, 100);
        bus.en_in = 4'b0010;
        step_sec(99);
        chk("a1_before", 32'(bus.ring), 32'h0);
        step_sec(100);
        chk("a1_ring", 32'(bus.ring), 32'h2);
        for (int k = 0; k < 5; k++) tick();
        chk("a1_hold", 32'(bus.ring), 32'h2);
        chk("a1_hold_snz", 32'(bus.snoozed), 32'h0);

        // 3: snooze at 100 -> re-ring at 400
        pulse_snooze();
        chk("snz_ring", 32'(bus.ring), 32'h0);
        chk("snz_state", 32'(bus.snoozed), 32'h2);
        for (int unsigned t = 101; t < 400; t++) step_sec(t);
        chk("snz_399", 32'(bus.ring), 32'h0);
        step_sec(400);
        chk("snz_400", 32'(bus.ring), 32'h2);
        chk("snz_400_s", 32'(bus.snoozed), 32'h0);
        pulse_end();
        chk("snz_end", 32'(bus.ring), 32'h0);

        // 4: midnight wrap of snooze target; alarm at 86399
        set_alarm(2, 86300);
        set_alarm(3, 86399);
        bus.en_in = 4'b1100;
        step_sec(86299);
        step_sec(86300);
        chk("wrap_ring2", 32'(bus.ring), 32'h4);
        pulse_snooze();
        chk("wrap_snz2", 32'(bus.snoozed), 32'h4);
        for (int unsigned t = 86301; t < 86399; t++) step_sec(t);
        step_sec(86399);
        chk("last_sec_ring", 32'(bus.ring), 32'h8);
        chk("last_sec_snz", 32'(bus.snoozed), 32'h4);
        pulse_snooze();
        chk("wrap_snz23", 32'(bus.snoozed), 32'hC);
        for (int unsigned t = 0; t < 200; t++) step_sec(t);
        chk("wrap_199", 32'(bus.ring), 32'h0);
        step_sec(200);
        chk("wrap_200_ring", 32'(bus.ring), 32'h4);
        chk("wrap_200_snz", 32'(bus.snoozed), 32'h8);
        pulse_end();
        chk("wrap_end_ring", 32'(bus.ring), 32'h0);
        chk("wrap_end_snz", 32'(bus.snoozed), 32'h0);

        // 5a: ring timeout after 60 unanswered seconds
        bus.en_in = 4'b0010;
        step_sec(99);
        step_sec(100);
        chk("to_ring", 32'(bus.ring), 32'h2);
        for (int unsigned t = 101; t < 160; t++) step_sec(t);
        chk("to_59", 32'(bus.ring), 32'h2);
        step_sec(160);
        chk("to_60", 32'(bus.ring), 32'h0);
        chk("to_60_any", 32'(bus.any_ring), 32'h0);
        chk("to_60_snz", 32'(bus.snoozed), 32'h0);

        // 5b: fourth snooze stops the channel
        step_sec(99);
        step_sec(100);
        chk("lim_ring0", 32'(bus.ring), 32'h2);
        pulse_snooze();
        chk("lim_snz1", 32'(bus.snoozed), 32'h2);
        step_sec(400);
        chk("lim_ring1", 32'(bus.ring), 32'h2);
        pulse_snooze();
        chk("lim_snz2", 32'(bus.snoozed), 32'h2);
        step_sec(700);
        chk("lim_ring2", 32'(bus.ring), 32'h2);
        pulse_snooze();
        chk("lim_snz3", 32'(bus.snoozed), 32'h2);
        step_sec(1000);
        chk("lim_ring3", 32'(bus.ring), 32'h2);
        pulse_snooze();
        chk("lim_stop_ring", 32'(bus.ring), 32'h0);
        chk("lim_stop_snz", 32'(bus.snoozed), 32'h0);

        // 6: two channels together, shared stop, set while ringing, async reset
        set_alarm(0, 500);
        set_alarm(2, 500);
        bus.en_in = 4'b0101;
        step_sec(499);
        step_sec(500);
        chk("dual_ring", 32'(bus.ring), 32'h5);
        chk("dual_any", 32'(bus.any_ring), 32'h1);
        pulse_end();
        chk("dual_end", 32'(bus.ring), 32'h0);
        chk("dual_end_any", 32'(bus.any_ring), 32'h0);
        step_sec(499);
        step_sec(500);
        chk("dual_ring2", 32'(bus.ring), 32'h5);
        set_alarm(0, 600);
        chk("set_idles", 32'(bus.ring), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ring", 32'(bus.ring), 32'h0);
        chk("arst_any", 32'(bus.any_ring), 32'h0);
        chk("arst_snz", 32'(bus.snoozed), 32'h0);
        tick();
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
